// File: rtl/hack_memory_map.sv
// Hack-style memory-mapped data space: general RAM, screen buffer and a
// read-only keyboard register, with a hardware clear engine that zeroes RAM
// and screen after reset or on request, a ready flag and a sticky fault flag.
module hack_memory_map #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned RAM_DEPTH    = 16384,
  parameter int unsigned SCREEN_BASE  = 16384,
  parameter int unsigned SCREEN_DEPTH = 8192,
  parameter int unsigned KBD_ADDR     = 24576
) (
  input  logic              i_clk,
  input  logic              i_reset,     // synchronous, active low
  input  logic [DATA_W-1:0] i_in_m,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_keyboard,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_out_m,
  output logic              o_ready,
  output logic              o_fault
);

  localparam int unsigned MAX     = (RAM_DEPTH > SCREEN_DEPTH) ? RAM_DEPTH : SCREEN_DEPTH;
  localparam int unsigned CNT_W   = (MAX > 1) ? $clog2(MAX) : 1;
  localparam int unsigned RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int unsigned SCR_AW  = (SCREEN_DEPTH > 1) ? $clog2(SCREEN_DEPTH) : 1;
  localparam int unsigned SCR_END = SCREEN_BASE + SCREEN_DEPTH;

  typedef enum logic {StClear, StIdle} state_e;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_fault, w_fault_d;

  logic [DATA_W-1:0]  r_ram    [RAM_DEPTH];
  logic [DATA_W-1:0]  r_screen [SCREEN_DEPTH];

  logic [31:0]        w_addr;
  logic [31:0]        w_cnt32;
  logic               w_is_ram, w_is_scr, w_is_kbd;
  logic [RAM_AW-1:0]  w_ram_addr_idx;
  logic [SCR_AW-1:0]  w_scr_addr_idx;

  logic               w_ram_we, w_scr_we;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic [SCR_AW-1:0]  w_scr_idx;
  logic [DATA_W-1:0]  w_wdata;

  // Address decode; compare in 32 bits so region bounds never truncate.
  always_comb begin
    w_addr         = 32'(i_address);
    w_cnt32        = 32'(r_cnt);
    w_is_ram       = w_addr < RAM_DEPTH;
    w_is_scr       = (w_addr >= SCREEN_BASE) && (w_addr < SCR_END);
    w_is_kbd       = w_addr == KBD_ADDR;
    w_ram_addr_idx = RAM_AW'(w_addr);
    w_scr_addr_idx = SCR_AW'(w_addr - SCREEN_BASE);
  end

  // Next-state, fault and memory write-port selection (clear engine vs CPU).
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_fault_d = r_fault;
    w_ram_we  = 1'b0;
    w_scr_we  = 1'b0;
    w_ram_idx = w_ram_addr_idx;
    w_scr_idx = w_scr_addr_idx;
    w_wdata   = i_in_m;
    if (!i_reset) begin
      // Reset held low keeps zeroing word 0 of both regions.
      w_ram_we  = 1'b1;
      w_scr_we  = 1'b1;
      w_ram_idx = '0;
      w_scr_idx = '0;
      w_wdata   = '0;
    end else begin
      unique case (r_state)
        StClear: begin
          w_ram_we  = w_cnt32 < RAM_DEPTH;
          w_scr_we  = w_cnt32 < SCREEN_DEPTH;
          w_ram_idx = RAM_AW'(r_cnt);
          w_scr_idx = SCR_AW'(r_cnt);
          w_wdata   = '0;
          if (r_cnt == CNT_W'(MAX - 1)) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
          // Any write attempt while not ready is illegal.
          if (i_load) w_fault_d = 1'b1;
        end
        StIdle: begin
          if (i_clear) begin
            // Clear wins over a simultaneous load, which is dropped silently.
            w_state_d = StClear;
            w_cnt_d   = '0;
            w_fault_d = 1'b0;
          end else if (i_load) begin
            if (w_is_ram)      w_ram_we  = 1'b1;
            else if (w_is_scr) w_scr_we  = 1'b1;
            else               w_fault_d = 1'b1;
          end
        end
        default: w_state_d = StClear;
      endcase
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StClear;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_fault <= w_fault_d;
    end
  end

  // RAM write port.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_ram[w_ram_idx] <= w_wdata;
  end

  // Screen write port.
  always_ff @(posedge i_clk) begin
    if (w_scr_we) r_screen[w_scr_idx] <= w_wdata;
  end

  // Zero-latency read mux, forced to zero while the clear engine runs.
  always_comb begin
    o_out_m = '0;
    if (r_state == StIdle) begin
      if (w_is_ram)      o_out_m = r_ram[w_ram_addr_idx];
      else if (w_is_scr) o_out_m = r_screen[w_scr_addr_idx];
      else if (w_is_kbd) o_out_m = i_keyboard;
    end
  end

  assign o_ready = r_state == StIdle;
  assign o_fault = r_fault;

endmodule

// File: tb/tb_hack_memory_map.sv
// Self-checking bench for hack_memory_map (small map: 16 RAM, 8 screen, kbd 24).
module tb_hack_memory_map;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_m;
  logic [15:0] address;
  logic        load;
  logic [15:0] keyboard;
  logic        clear;
  logic [15:0] out_m;
  logic        ready;
  logic        fault;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       tag;
    int          sel;   // 0 = out_m, 1 = ready, 2 = fault
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];

  hack_memory_map #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .RAM_DEPTH   (16),
    .SCREEN_BASE (16),
    .SCREEN_DEPTH(8),
    .KBD_ADDR    (24)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_in_m    (in_m),
    .i_address (address),
    .i_load    (load),
    .i_keyboard(keyboard),
    .i_clear   (clear),
    .o_out_m   (out_m),
    .o_ready   (ready),
    .o_fault   (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Compare every pending expectation against the DUT outputs as they are now.
  task automatic sb_drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       check(e.tag, out_m, e.exp);
        1:       check(e.tag, {15'd0, ready}, e.exp);
        default: check(e.tag, {15'd0, fault}, e.exp);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input string tag, input logic [15:0] exp);
    address = a;
    sb_push(tag, 0, exp);
    #1;
    sb_drain();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address = a;
    in_m    = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Expect ready low after edges 1..n-1 and high after edge n.
  task automatic expect_clear(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      sb_push($sformatf("%s_rdy%0d", tag, i), 1, (i == n) ? 16'd1 : 16'd0);
      if (i < n) sb_push($sformatf("%s_out%0d", tag, i), 0, 16'd0);
      sb_drain();
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_m     = '0;
    address  = '0;
    load     = 1'b0;
    keyboard = '0;
    clear    = 1'b0;

    // 1. Reset for two edges, then 16-edge clear.
    tick();
    tick();
    sb_push("rst_ready", 1, 16'd0);
    sb_push("rst_fault", 2, 16'd0);
    sb_push("rst_out", 0, 16'd0);
    sb_drain();
    reset = 1'b1;
    expect_clear("t1", 16);
    for (int a = 0; a < 24; a++) rd(16'(a), $sformatf("t1_zero%0d", a), 16'd0);

    // 2. Basic writes, including region boundaries.
    address = 16'd5;
    in_m    = 16'd12345;
    load    = 1'b1;
    sb_push("t2_rdw_old", 0, 16'd0);
    #1;
    sb_drain();
    tick();
    load = 1'b0;
    wr(16'd17, 16'd1000);
    wr(16'd15, 16'd4242);
    wr(16'd23, 16'd2323);
    rd(16'd5,  "t2_a5", 16'd12345);
    rd(16'd17, "t2_a17", 16'd1000);
    rd(16'd1,  "t2_a1", 16'd0);
    rd(16'd15, "t2_a15", 16'd4242);
    rd(16'd23, "t2_a23", 16'd2323);
    rd(16'd16, "t2_a16", 16'd0);
    sb_push("t2_fault", 2, 16'd0);
    sb_drain();

    // 3. Keyboard read and illegal writes.
    keyboard = 16'd75;
    rd(16'd24, "t3_kbd", 16'd75);
    wr(16'd24, 16'd9);
    sb_push("t3_fault_kbd", 2, 16'd1);
    sb_drain();
    rd(16'd24, "t3_kbd_after", 16'd75);
    wr(16'd30, 16'd9);
    sb_push("t3_fault_unmap", 2, 16'd1);
    sb_drain();
    rd(16'd30, "t3_unmap", 16'd0);

    // 4. Software clear, with an illegal write during the clear.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb_push("t4_ready", 1, 16'd0);
    sb_push("t4_fault_clr", 2, 16'd0);
    sb_drain();
    address = 16'd3;
    in_m    = 16'd55;
    load    = 1'b1;
    tick();
    load = 1'b0;
    sb_push("t4_fault_busy", 2, 16'd1);
    sb_push("t4_ready1", 1, 16'd0);
    sb_drain();
    expect_clear("t4", 15);
    rd(16'd5,  "t4_a5", 16'd0);
    rd(16'd17, "t4_a17", 16'd0);
    rd(16'd3,  "t4_a3", 16'd0);

    // 5. Reset mid-clear at cnt=7 restarts the full 16-edge clear.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    sb_push("t5_ready_mid", 1, 16'd0);
    sb_drain();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb_push("t5_ready_rst", 1, 16'd0);
    sb_push("t5_fault_rst", 2, 16'd0);
    sb_drain();
    expect_clear("t5", 16);

    // 6. clear and load together in IDLE: clear wins, no fault.
    address = 16'd2;
    in_m    = 16'd77;
    load    = 1'b1;
    clear   = 1'b1;
    tick();
    load  = 1'b0;
    clear = 1'b0;
    sb_push("t6_ready", 1, 16'd0);
    sb_push("t6_fault", 2, 16'd0);
    sb_drain();
    expect_clear("t6", 16);
    rd(16'd2, "t6_a2", 16'd0);
    sb_push("t6_fault_end", 2, 16'd0);
    sb_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/hack_memory_map.md
Name: hack_memory_map

Overview:
- Parametrised successor to the single-region data memory: a Hack-style memory-mapped data space with three regions (general RAM, screen buffer, read-only keyboard register).
- Adds a hardware clear engine that zeroes RAM and screen after reset or on request, plus a ready flag and a sticky fault flag for illegal accesses.
- Sits between the CPU data port (inM/address/load/outM) and the screen and keyboard peripherals.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width.
- RAM_DEPTH, 16384, RAM words, mapped at address 0.
- SCREEN_BASE, 16384, first screen address.
- SCREEN_DEPTH, 8192, screen words.
- KBD_ADDR, 24576, keyboard register address.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- inM  input  DATA_W  write data.
- address  input  ADDR_W  CPU word address.
- load  input  1  write enable.
- keyboard  input  DATA_W  live keyboard scan code.
- clear  input  1  request a clear of RAM and screen.
- outM  output  DATA_W  read data for the current address.
- ready  output  1  1 = idle and accepting writes.
- fault  output  1  sticky illegal-access flag.

Behaviour:
- Decode:
  - RAM when address < RAM_DEPTH.
  - SCREEN when SCREEN_BASE <= address < SCREEN_BASE+SCREEN_DEPTH (index = address-SCREEN_BASE).
  - KBD when address == KBD_ADDR.
  - Anything else is unmapped.
- Read:
  - outM is combinational (zero-latency) from address while ready=1.
  - RAM and SCREEN return the stored word; KBD returns keyboard; unmapped returns 0.
  - outM=0 whenever ready=0.
- Write:
  - Occurs at the rising edge when load=1 and ready=1, and the address is RAM or SCREEN.
  - Read-during-write at the same address shows the old word until the edge.
- Fault:
  - Set at the edge where load=1 and either ready=0, the address is KBD, or the address is unmapped. None of these writes is performed.
  - fault stays set until reset is low or a clear starts.
- FSM states: CLEAR, IDLE. Counter cnt has width clog2(MAX), where MAX = max(RAM_DEPTH, SCREEN_DEPTH).
- reset low, sampled at an edge:
  - state=CLEAR, cnt=0, ready=0, fault=0.
  - Held while reset stays low; each edge also zeroes RAM[0] and SCREEN[0].
- CLEAR with reset high, at each edge:
  - Write 0 to RAM[cnt] if cnt < RAM_DEPTH.
  - Write 0 to SCREEN[cnt] if cnt < SCREEN_DEPTH.
  - If cnt == MAX-1, go to IDLE and set ready=1; otherwise cnt+1.
  - ready rises exactly MAX edges after the first edge with reset high.
- IDLE with clear=1 at an edge:
  - Go to CLEAR, cnt=0, ready=0, fault=0.
  - A simultaneous load is not performed and does not set fault.
- clear while in CLEAR is ignored (no restart).
- reset low mid-clear restarts the clear from cnt=0.
- reset takes priority over clear and load.
- Reset values: ready=0, fault=0, outM=0. Memory contents are defined only after a clear completes (all zero).

Test Plan:
All tests use RAM_DEPTH=16, SCREEN_BASE=16, SCREEN_DEPTH=8, KBD_ADDR=24.

1. Reset and clear timing: reset low for 2 edges, then high.
   - Required: ready=0 and outM=0 for 15 edges; ready=1 after the 16th edge.
   - Reads of addresses 0..15 and 16..23 return 0.
2. Basic write/read: write 12345 to address 5 and 1000 to address 17, then read back.
   - Required: outM=12345 at address 5; outM=1000 at address 17; address 1 still reads 0.
3. Keyboard read and illegal writes:
   - keyboard=75, address=24: outM=75.
   - load=1 with inM=9 at address 24: fault=1 next edge; outM still 75.
   - load=1 at address 30: fault stays 1; outM=0 at address 30.
4. Software clear: after test 2, pulse clear=1 for 1 cycle.
   - Required: ready=0 and fault=0 on the next edge.
   - load=1 to address 3 during CLEAR sets fault=1.
   - ready returns 16 edges after clear was sampled; addresses 5, 17 and 3 all read 0.
5. Reset mid-clear: assert reset low at cnt=7 for 1 edge, then release.
   - Required: ready stays 0 for a further 16 edges from release, then 1.
6. clear and load in the same IDLE cycle (address 2, inM=77).
   - Required: CLEAR is entered and fault=0; address 2 reads 0 after ready=1.
